address_generator: RTL and testbench

ADDRESS_GENERATOR -- requirements
Module: address_generator

---
 rtl/address_generator.sv | 76 +++++++
 tb/tb_address_generator.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/address_generator.sv
// rtl/address_generator.sv - pixel byte-address generator for strand-mapped frame buffers
//
// Purpose: converts (strand_offset, strand_idx, strand_length) into the byte
// address of the pixel's first colour byte (3 bytes per pixel). Indices past
// the end of the strand wrap to the strand's first pixel. Two-stage pipeline,
// one result per clock, latency 2 clocks, no handshake.
//
// Ports:
//   clk            - rising-edge clock
//   rst_n          - asynchronous active-low reset, clears all pipeline state
//   strand_offset  - first pixel number of the strand
//   strand_idx     - pixel index within the strand
//   strand_length  - number of pixels in the strand (0 = every index wraps)
//   addr           - registered byte address, pixel_number * 3

module address_generator #(
  parameter int MEM_ADDR_WIDTH     = 24,
  parameter int STRAND_PARAM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_offset,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_idx,
  input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
  output logic [MEM_ADDR_WIDTH-1:0]     addr
);

  localparam int PN_W   = STRAND_PARAM_WIDTH + 1;
  localparam int PROD_W = STRAND_PARAM_WIDTH + 3;

  // Stage 1: range check plus both pixel-number candidates.
  logic            in_range_q, in_range_d;
  logic [PN_W-1:0] sum_q, sum_d;
  logic [PN_W-1:0] base_q, base_d;

  // Stage 2: scaled byte address.
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;

  logic [PN_W-1:0]                pixel_num;
  logic [PROD_W-1:0]              pixel_ext;
  logic [PROD_W-1:0]              prod;
  logic [MEM_ADDR_WIDTH+PROD_W-1:0] prod_wide;

  always_comb begin
    in_range_d = (strand_idx < strand_length);
    sum_d      = {1'b0, strand_offset} + {1'b0, strand_idx};
    base_d     = {1'b0, strand_offset};
  end

  always_comb begin
    pixel_num = in_range_q ? sum_q : base_q;
    pixel_ext = {2'b00, pixel_num};
    // x3 as shift-and-add so no multiplier is inferred
    prod      = (pixel_ext << 1) + pixel_ext;
    // Pad then slice: covers both zero-extension and modulo truncation
    prod_wide = {{MEM_ADDR_WIDTH{1'b0}}, prod};
    addr_d    = prod_wide[MEM_ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_range_q <= 1'b0;
      sum_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
    end else begin
      in_range_q <= in_range_d;
      sum_q      <= sum_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: tb/tb_address_generator.sv
// tb/tb_address_generator.sv - randomized self-checking bench for address_generator

module tb_address_generator;

  logic        clk;
  logic        rst_n;
  logic [15:0] strand_offset;
  logic [15:0] strand_idx;
  logic [15:0] strand_length;
  logic [23:0] addr;

  int n_cmp;
  int n_bad;

  // Expected stage contents in flight; front is what addr takes at next edge.
  longint exp_q[$];
  longint exp_addr;

  address_generator #(
    .MEM_ADDR_WIDTH    (24),
    .STRAND_PARAM_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .strand_offset(strand_offset),
    .strand_idx   (strand_idx),
    .strand_length(strand_length),
    .addr         (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_addr(input longint off, input longint idx, input longint len);
    longint pix;
    pix = (idx < len) ? off + idx : off;
    return (pix * 3) % (longint'(1) << 24);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(0);
    exp_addr = 0;
  endtask

  // Called at a negedge: apply inputs, run one clock, check at the next negedge.
  task automatic cycle(input string tag, input logic [15:0] o, input logic [15:0] i,
                       input logic [15:0] l);
    strand_offset = o;
    strand_idx    = i;
    strand_length = l;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_q.push_back(ref_addr(o, i, l));
      exp_addr = exp_q.pop_front();
    end
    @(negedge clk);
    check_eq(tag, addr, exp_addr);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    strand_offset = 16'd0;
    strand_idx    = 16'd0;
    strand_length = 16'd100;
    model_reset();

    // Reset pulse
    @(negedge clk);
    check_eq("reset_addr", addr, 0);
    cycle("in_reset", 16'd0, 16'd0, 16'd100);
    rst_n = 1'b1;
    cycle("post_reset0", 16'd0, 16'd0, 16'd100);
    cycle("post_reset1", 16'd0, 16'd0, 16'd100);
    check_eq("post_reset_lit", addr, 0);

    // In-range run at offset 320
    cycle("o320_i1", 16'd320, 16'd1, 16'd100);
    cycle("o320_i50", 16'd320, 16'd50, 16'd100);
    check_eq("lit_963", addr, 963);
    cycle("o320_i99", 16'd320, 16'd99, 16'd100);
    check_eq("lit_1110", addr, 1110);
    cycle("o320_i100", 16'd320, 16'd100, 16'd100);
    check_eq("lit_1257", addr, 1257);
    cycle("o320_i101", 16'd320, 16'd101, 16'd100);
    check_eq("lit_960a", addr, 960);
    cycle("o640_i1", 16'd640, 16'd1, 16'd100);
    check_eq("lit_960b", addr, 960);
    cycle("o640_i50", 16'd640, 16'd50, 16'd100);
    check_eq("lit_1923", addr, 1923);
    cycle("o640_i100", 16'd640, 16'd100, 16'd100);
    check_eq("lit_2070", addr, 2070);
    cycle("o640_i101", 16'd640, 16'd101, 16'd100);
    check_eq("lit_1920a", addr, 1920);
    cycle("len0", 16'd5, 16'd0, 16'd0);
    check_eq("lit_1920b", addr, 1920);
    cycle("max", 16'hFFFF, 16'hFFFE, 16'hFFFF);
    check_eq("lit_15", addr, 15);
    cycle("flush0", 16'd0, 16'd0, 16'd0);
    check_eq("lit_393207", addr, 393207);
    cycle("idx_eq_len", 16'hFFFF, 16'hFFFF, 16'hFFFF);
    cycle("flush1", 16'd0, 16'd0, 16'd0);
    check_eq("lit_idx_eq_len", addr, 196605);

    // Randomized traffic, biased toward the length boundary
    for (int n = 0; n < 300; n++) begin
      logic [15:0] o, i, l;
      o = 16'($urandom);
      l = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom);
      case ($urandom_range(0, 3))
        0:       i = l - 16'd1;
        1:       i = l;
        2:       i = l + 16'd1;
        default: i = 16'($urandom);
      endcase
      cycle("rand", o, i, l);
    end

    // Mid-stream asynchronous reset with the pipeline full
    cycle("fill0", 16'd1000, 16'd7, 16'd50);
    cycle("fill1", 16'd2000, 16'd9, 16'd50);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear", addr, 0);
    model_reset();
    @(negedge clk);
    cycle("hold_reset", 16'd3000, 16'd1, 16'd50);
    rst_n = 1'b1;
    cycle("release0", 16'd400, 16'd2, 16'd10);
    check_eq("no_stale0", addr, 0);
    cycle("release1", 16'd400, 16'd3, 16'd10);
    check_eq("first_valid", addr, 1206);
    cycle("release2", 16'd0, 16'd0, 16'd0);
    check_eq("second_valid", addr, 1209);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
